// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and default constants for the register-file write arbiter
package rf_arb_pkg;
  localparam int XLEN = 64;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_STARVE_LIMIT = 8;
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: pipeline writeback, late-unit, issue, decode-query and register-file signals
interface rf_write_arbiter_if #(
  parameter int XLEN = 64,
  parameter int FIFO_DEPTH = 4
);
  logic                         wb_we;
  logic [4:0]                   wb_rd;
  logic [XLEN-1:0]              wb_data;
  logic                         wb_stall;
  logic                         lu_valid;
  logic                         lu_ready;
  logic [4:0]                   lu_rd;
  logic [XLEN-1:0]              lu_data;
  logic                         iss_valid;
  logic [4:0]                   iss_rd;
  logic [4:0]                   rs1;
  logic [4:0]                   rs2;
  logic                         rs1_busy;
  logic                         rs2_busy;
  logic                         rf_we;
  logic [4:0]                   rf_a3;
  logic [XLEN-1:0]              rf_wd;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  modport master (
    output wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data, iss_valid, iss_rd, rs1, rs2,
    input  wb_stall, lu_ready, rs1_busy, rs2_busy, rf_we, rf_a3, rf_wd, fifo_count
  );
  modport slave (
    input  wb_we, wb_rd, wb_data, lu_valid, lu_rd, lu_data, iss_valid, iss_rd, rs1, rs2,
    output wb_stall, lu_ready, rs1_busy, rs2_busy, rf_we, rf_a3, rf_wd, fifo_count
  );
endinterface

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: synchronous FIFO buffering late-unit writes, with occupancy count
module rf_wb_fifo #(
  parameter int W = 69,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  assign dout = mem[rp];
  // storage write; contents need no reset since count gates validity
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // pointers wrap naturally at DEPTH; caller never pushes when full or pops when empty
  always_ff @(posedge clk)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates pipeline and buffered late-unit writes onto one register-file port
module rf_write_arbiter #(
  parameter int XLEN = rf_arb_pkg::XLEN,
  parameter int FIFO_DEPTH = rf_arb_pkg::DEF_FIFO_DEPTH,
  parameter int STARVE_LIMIT = rf_arb_pkg::DEF_STARVE_LIMIT
) (
  input logic               clk,
  input logic               rst,
  rf_write_arbiter_if.slave bus
);
  import rf_arb_pkg::*;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  logic [XLEN+4:0] head;
  logic [CW-1:0]   count;
  logic [AGW-1:0]  age;
  logic [31:0]     busy;
  logic [31:0]     busy_nxt;
  logic [4:0]      head_rd;
  logic            head_valid;
  logic            starved;
  logic            use_lu;
  logic            pop;
  logic            push;
  assign head_rd = head[XLEN+4:XLEN];
  rf_wb_fifo #(.W(XLEN + 5), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.lu_rd, bus.lu_data}),
    .dout  (head),
    .count (count)
  );
  // grant: starved head beats the pipeline, pipeline beats an ordinary head
  always_comb begin
    head_valid      = count != '0;
    starved         = head_valid && age == AGW'(STARVE_LIMIT);
    use_lu          = head_valid && (starved || !bus.wb_we);
    pop             = use_lu && !rst;
    bus.lu_ready    = !rst && count < CW'(FIFO_DEPTH);
    push            = bus.lu_valid && bus.lu_ready;
    bus.wb_stall    = !rst && starved && bus.wb_we;
    bus.rf_a3       = use_lu ? head_rd : bus.wb_rd;
    bus.rf_wd       = use_lu ? head[XLEN-1:0] : bus.wb_data;
    bus.rf_we       = !rst && (use_lu || bus.wb_we) && bus.rf_a3 != 5'd0;
    bus.fifo_count  = count;
    bus.rs1_busy    = busy[bus.rs1];
    bus.rs2_busy    = busy[bus.rs2];
    busy_nxt        = busy & ~(pop ? 32'd1 << head_rd : 32'd0);
    busy_nxt        = (busy_nxt | (bus.iss_valid ? 32'd1 << bus.iss_rd : 32'd0)) & ~32'd1;
  end
  // head age: restarts for each new head, saturates at the starvation limit
  always_ff @(posedge clk)
    if (rst || pop || !head_valid) age <= '0;
    else if (age != AGW'(STARVE_LIMIT)) age <= age + 1'b1;
  // pending-write scoreboard; a new issue outranks the clear of the same rd
  always_ff @(posedge clk)
    if (rst) busy <= '0;
    else busy <= busy_nxt;
  // scoreboard misuse: reissuing a pending rd, or a late result nobody is waiting for
  always_ff @(posedge clk)
    if (!rst) begin
      assert (!(bus.iss_valid && bus.iss_rd != 5'd0 && busy[bus.iss_rd] && !(pop && head_rd == bus.iss_rd)));
      assert (!(push && bus.lu_rd != 5'd0 && !busy[bus.lu_rd]));
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenarios plus randomized traffic against a queue-based model
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;
  localparam int XL = 64;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int passed = 0;
  rf_wr_t q[$];
  int age = 0;
  bit [31:0] busy_m = '0;
  bit last_acc = 0;
  rf_write_arbiter_if #(.XLEN(XL), .FIFO_DEPTH(DEPTH)) b ();
  rf_write_arbiter #(.XLEN(XL), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );
  always #5 clk = ~clk;

  task automatic tick();
    bit hv, lsel, acc, iv;
    logic [4:0] ir, lr;
    logic [XL-1:0] ld;
    hv = q.size() > 0;
    lsel = hv && (age == LIMIT || !b.wb_we);
    acc = b.lu_valid && q.size() < DEPTH;
    iv = b.iss_valid; ir = b.iss_rd; lr = b.lu_rd; ld = b.lu_data;
    @(posedge clk);
    if (rst) begin
      q.delete(); age = 0; busy_m = '0; last_acc = 0;
    end else begin
      if (lsel) begin
        if (q[0].rd != 0) busy_m[q[0].rd] = 0;
        void'(q.pop_front());
      end
      if (iv && ir != 0) busy_m[ir] = 1;
      if (acc) q.push_back('{rd: lr, data: ld});
      age = (lsel || !hv) ? 0 : (age < LIMIT ? age + 1 : age);
      last_acc = acc;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    b.wb_we = 0; b.wb_rd = 0; b.wb_data = 0;
    b.lu_valid = 0; b.lu_rd = 0; b.lu_data = 0;
    b.iss_valid = 0; b.iss_rd = 0; b.rs1 = 0; b.rs2 = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    b.iss_valid = 1; b.iss_rd = rd;
    tick();
    b.iss_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    #1;
    total++; if (b.rf_we !== 0) $display("FAIL reset_rf_we: got %0b want 0", b.rf_we); else passed++;
    total++; if (b.lu_ready !== 0) $display("FAIL reset_lu_ready: got %0b want 0", b.lu_ready); else passed++;
    total++; if (b.wb_stall !== 0) $display("FAIL reset_wb_stall: got %0b want 0", b.wb_stall); else passed++;
    rst = 0;
    #1;
    total++; if (b.fifo_count !== 0) $display("FAIL reset_count: got %0d want 0", b.fifo_count); else passed++;
    total++; if (b.lu_ready !== 1) $display("FAIL reset_ready_after: got %0b want 1", b.lu_ready); else passed++;
  endtask

  task automatic test_late_write();
    issue(5);
    b.rs1 = 5; #1;
    total++; if (b.rs1_busy !== 1) $display("FAIL late_busy_set: got %0b want 1", b.rs1_busy); else passed++;
    b.lu_valid = 1; b.lu_rd = 5; b.lu_data = 'hAA;
    tick();
    b.lu_valid = 0; #1;
    total++; if ({b.rf_we, b.rf_a3} !== {1'b1, 5'd5} || b.rf_wd !== 64'hAA)
      $display("FAIL late_write: got we=%0b a3=%0d wd=%0h want we=1 a3=5 wd=aa", b.rf_we, b.rf_a3, b.rf_wd); else passed++;
    total++; if (b.rs1_busy !== 1) $display("FAIL late_busy_hold: got %0b want 1", b.rs1_busy); else passed++;
    tick(); #1;
    total++; if (b.rs1_busy !== 0) $display("FAIL late_busy_clear: got %0b want 0", b.rs1_busy); else passed++;
    total++; if (b.rf_we !== 0) $display("FAIL late_idle: got %0b want 0", b.rf_we); else passed++;
  endtask

  task automatic test_starve();
    int bad = 0;
    issue(7);
    b.wb_we = 1; b.wb_rd = 3; b.wb_data = 'h33;
    b.lu_valid = 1; b.lu_rd = 7; b.lu_data = 'h77; #1;
    total++; if (b.rf_a3 !== 3 || b.wb_stall !== 0) $display("FAIL starve_first: got a3=%0d stall=%0b want a3=3 stall=0", b.rf_a3, b.wb_stall); else passed++;
    tick();
    b.lu_valid = 0;
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      if (b.wb_stall !== 0 || b.rf_a3 !== 3 || b.rf_we !== 1) bad++;
      tick();
    end
    total++; if (bad != 0) $display("FAIL starve_wait: got %0d bad cycles want 0", bad); else passed++;
    #1;
    total++; if (b.wb_stall !== 1 || b.rf_a3 !== 7 || b.rf_wd !== 64'h77)
      $display("FAIL starve_force: got stall=%0b a3=%0d wd=%0h want stall=1 a3=7 wd=77", b.wb_stall, b.rf_a3, b.rf_wd); else passed++;
    tick(); #1;
    total++; if (b.wb_stall !== 0 || b.rf_a3 !== 3 || b.rf_wd !== 64'h33)
      $display("FAIL starve_resume: got stall=%0b a3=%0d wd=%0h want stall=0 a3=3 wd=33", b.wb_stall, b.rf_a3, b.rf_wd); else passed++;
    tick();
    b.wb_we = 0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) issue(5'(10 + i));
    b.wb_we = 1; b.wb_rd = 3; b.wb_data = 'h1;
    for (int i = 0; i < 5; i++) begin
      b.lu_valid = 1; b.lu_rd = 5'(10 + i); b.lu_data = 64'(256 + i); #1;
      total++; if (b.lu_ready !== (i < 4)) $display("FAIL full_ready_%0d: got %0b want %0b", i, b.lu_ready, i < 4); else passed++;
      tick();
    end
    #1;
    total++; if (b.fifo_count !== 4) $display("FAIL full_count: got %0d want 4", b.fifo_count); else passed++;
    b.lu_valid = 0; b.wb_we = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (b.rf_a3 !== 5'(10 + i) || b.rf_wd !== 64'(256 + i))
        $display("FAIL full_order_%0d: got a3=%0d wd=%0h want a3=%0d wd=%0h", i, b.rf_a3, b.rf_wd, 10 + i, 256 + i); else passed++;
      tick();
    end
    b.lu_valid = 1; b.lu_rd = 14; b.lu_data = 'h104;
    tick();
    b.lu_valid = 0;
    tick();
  endtask

  task automatic test_busy_collision();
    issue(9);
    b.lu_valid = 1; b.lu_rd = 9; b.lu_data = 'h99;
    tick();
    b.lu_valid = 0; b.iss_valid = 1; b.iss_rd = 9; #1;
    total++; if (b.rf_a3 !== 9 || b.rf_we !== 1) $display("FAIL coll_write: got a3=%0d we=%0b want a3=9 we=1", b.rf_a3, b.rf_we); else passed++;
    tick();
    b.iss_valid = 0; b.rs2 = 9; #1;
    total++; if (b.rs2_busy !== 1) $display("FAIL coll_busy: got %0b want 1", b.rs2_busy); else passed++;
    b.lu_valid = 1; b.lu_rd = 9;
    tick();
    b.lu_valid = 0;
    tick(); #1;
    total++; if (b.rs2_busy !== 0) $display("FAIL coll_clear: got %0b want 0", b.rs2_busy); else passed++;
  endtask

  task automatic test_rd_zero();
    b.wb_we = 1; b.wb_rd = 0; b.wb_data = 'hFF; #1;
    total++; if (b.rf_we !== 0 || b.wb_stall !== 0) $display("FAIL zero_wb: got we=%0b stall=%0b want 0 0", b.rf_we, b.wb_stall); else passed++;
    tick();
    b.wb_we = 0; b.lu_valid = 1; b.lu_rd = 0; b.lu_data = 'h5;
    tick();
    b.lu_valid = 0; #1;
    total++; if (b.fifo_count !== 1 || b.rf_we !== 0) $display("FAIL zero_lu: got count=%0d we=%0b want 1 0", b.fifo_count, b.rf_we); else passed++;
    tick(); #1;
    total++; if (b.fifo_count !== 0) $display("FAIL zero_pop: got %0d want 0", b.fifo_count); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) issue(5'(20 + i));
    b.wb_we = 1; b.wb_rd = 2; b.wb_data = 'h2;
    for (int i = 0; i < 3; i++) begin
      b.lu_valid = 1; b.lu_rd = 5'(20 + i); b.lu_data = 64'(i);
      tick();
    end
    b.lu_valid = 0; b.rs1 = 20; b.rs2 = 21; #1;
    total++; if (b.fifo_count !== 3) $display("FAIL mid_count_pre: got %0d want 3", b.fifo_count); else passed++;
    rst = 1; #1;
    total++; if (b.rf_we !== 0 || b.wb_stall !== 0) $display("FAIL mid_in_rst: got we=%0b stall=%0b want 0 0", b.rf_we, b.wb_stall); else passed++;
    tick();
    rst = 0; b.wb_we = 0; #1;
    total++; if (b.fifo_count !== 0 || b.rf_we !== 0) $display("FAIL mid_after: got count=%0d we=%0b want 0 0", b.fifo_count, b.rf_we); else passed++;
    total++; if (b.rs1_busy !== 0 || b.rs2_busy !== 0) $display("FAIL mid_busy: got %0b %0b want 0 0", b.rs1_busy, b.rs2_busy); else passed++;
  endtask

  task automatic test_random();
    int pend[$];
    bit hold_wb = 0;
    int errs = 0;
    for (int n = 0; n < 400; n++) begin
      bit hv, lsel, e_stall, e_we;
      logic [4:0] e_a3, r;
      logic [XL-1:0] e_wd;
      if (!hold_wb) begin
        b.wb_we = $urandom_range(0, 2) != 0;
        b.wb_rd = 5'($urandom_range(0, 31));
        b.wb_data = {$urandom, $urandom};
      end
      if (!(b.lu_valid && !last_acc)) begin
        b.lu_valid = 0;
        if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
          b.lu_valid = 1; b.lu_rd = 5'(pend[0]); b.lu_data = {$urandom, $urandom};
        end else if ($urandom_range(0, 15) == 0) begin
          b.lu_valid = 1; b.lu_rd = 0; b.lu_data = {$urandom, $urandom};
        end
      end
      r = 5'($urandom_range(1, 31));
      b.iss_valid = $urandom_range(0, 2) == 0 && !busy_m[r];
      b.iss_rd = r;
      b.rs1 = 5'($urandom_range(0, 31));
      b.rs2 = 5'($urandom_range(0, 31));
      #1;
      hv = q.size() > 0;
      lsel = hv && (age == LIMIT || !b.wb_we);
      e_stall = hv && age == LIMIT && b.wb_we;
      e_a3 = lsel ? q[0].rd : b.wb_rd;
      e_wd = lsel ? q[0].data : b.wb_data;
      e_we = (lsel || b.wb_we) && e_a3 != 0;
      total++;
      if (b.wb_stall !== e_stall || b.rf_we !== e_we || b.lu_ready !== (q.size() < DEPTH) ||
          b.fifo_count !== q.size() || b.rs1_busy !== busy_m[b.rs1] || b.rs2_busy !== busy_m[b.rs2] ||
          (e_we && (b.rf_a3 !== e_a3 || b.rf_wd !== e_wd))) begin
        if (errs < 10)
          $display("FAIL rand_%0d: got stall=%0b we=%0b a3=%0d wd=%0h cnt=%0d rdy=%0b busy=%0b%0b want stall=%0b we=%0b a3=%0d wd=%0h cnt=%0d rdy=%0b busy=%0b%0b",
                   n, b.wb_stall, b.rf_we, b.rf_a3, b.rf_wd, b.fifo_count, b.lu_ready, b.rs1_busy, b.rs2_busy,
                   e_stall, e_we, e_a3, e_wd, q.size(), q.size() < DEPTH, busy_m[b.rs1], busy_m[b.rs2]);
        errs++;
      end else passed++;
      hold_wb = e_stall;
      tick();
      if (last_acc && b.lu_rd != 0) void'(pend.pop_front());
      if (b.iss_valid) pend.push_back(int'(b.iss_rd));
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_late_write();
    test_starve();
    test_full();
    test_busy_collision();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
